// File: rtl/inv_kin.sv
// rtl/inv_kin.sv - two-link planar arm inverse kinematics, signed Q16.15, free-running iterative loop
// One vectoring CORDIC is reused for the three atan2 evaluations; outputs change only in UPDATE.
module inv_kin #(
  parameter int BIT_WIDTH    = 32,
  parameter int FRACTIONS    = 15,
  parameter int CORDIC_ITERS = 16
) (
  input  logic [BIT_WIDTH-1:0] x,
  input  logic [BIT_WIDTH-1:0] y,
  output logic [BIT_WIDTH-1:0] theta1,
  output logic [BIT_WIDTH-1:0] theta2,
  input  logic                 clock,
  input  logic                 rst
);
  localparam int W    = BIT_WIDTH;
  localparam int CW   = W + 4;
  localparam int QW   = FRACTIONS + 1;
  localparam int RW   = 2 * QW;
  localparam int RRW  = FRACTIONS + 7;
  localparam int CNTW = $clog2(CORDIC_ITERS + FRACTIONS + 2);
  localparam int SHW  = $clog2(CW);

  localparam logic signed [W-1:0] ONE    = W'(1 << FRACTIONS);
  localparam logic signed [W-1:0] ONE_SQ = W'(1 << (2 * FRACTIONS));
  localparam logic signed [W-1:0] PI     = W'(102944);
  localparam logic signed [W-1:0] PI_2   = W'(51472);
  localparam logic signed [W-1:0] TWO_PI = W'(205888);
  localparam logic [CNTW-1:0]     SQ_LAST = CNTW'(FRACTIONS);
  localparam logic [CNTW-1:0]     AT_LAST = CNTW'(CORDIC_ITERS);

  typedef enum logic [2:0] {IDLE, SQUARE, SQRT, ATAN_A, ATAN_B, ATAN_C, UPDATE} state_t;
  state_t state, state_nx;

  logic [CNTW-1:0]        cnt;
  logic signed [W-1:0]    xr, yr, c, s;
  logic [RW-1:0]          rad;
  logic signed [RRW-1:0]  sq_r;
  logic [QW-1:0]          sq_q;
  logic signed [CW-1:0]   cx, cy;
  logic signed [W-1:0]    cz;
  logic                   czero;
  logic signed [W-1:0]    ang_a, ang_b, ang_c;

  function automatic logic signed [W-1:0] atan_tab(input int i);
    case (i)
      0:  return W'(25736);
      1:  return W'(15193);
      2:  return W'(8027);
      3:  return W'(4075);
      4:  return W'(2045);
      5:  return W'(1024);
      6:  return W'(512);
      7:  return W'(256);
      8:  return W'(128);
      9:  return W'(64);
      10: return W'(32);
      11: return W'(16);
      12: return W'(8);
      13: return W'(4);
      14: return W'(2);
      15: return W'(1);
      default: return '0;
    endcase
  endfunction

  // r2 = x^2 + y^2 in Q.15; c = 2*r2 - 1 saturates at +1.0 (r2 >= 0 so the low side never clips)
  logic [W-1:0]          xabs, yabs;
  logic [2*W-1:0]        sum, r2;
  logic signed [W-1:0]   c_sq;
  logic [RW-1:0]         rad_sq;
  always_comb begin
    xabs = xr[W-1] ? W'(-xr) : xr;
    yabs = yr[W-1] ? W'(-yr) : yr;
    sum  = ({{W{1'b0}}, xabs} * {{W{1'b0}}, xabs}) + ({{W{1'b0}}, yabs} * {{W{1'b0}}, yabs});
    r2   = sum >> FRACTIONS;
    if (r2 >= (2*W)'(ONE)) c_sq = ONE;
    else                   c_sq = signed'({r2[W-2:0], 1'b0}) - ONE;
    rad_sq = RW'(ONE_SQ - c_sq * c_sq);
  end

  // non-restoring square root, two radicand bits per step
  logic signed [RRW-1:0] r_sh, r_nx, q_sub, q_add;
  logic [QW-1:0]         q_nx;
  always_comb begin
    r_sh  = {sq_r[RRW-3:0], rad[RW-1:RW-2]};
    q_sub = signed'({{(RRW-QW-2){1'b0}}, sq_q, 2'b01});
    q_add = signed'({{(RRW-QW-2){1'b0}}, sq_q, 2'b11});
    r_nx  = sq_r[RRW-1] ? r_sh + q_add : r_sh - q_sub;
    q_nx  = {sq_q[QW-2:0], ~r_nx[RRW-1]};
  end

  // CORDIC load: operand select, quadrant pre-rotation so x >= 0, then normalise small vectors
  logic signed [W-1:0]   in_x, in_y, pz;
  logic signed [CW-1:0]  ex, ey, px, py, nx, ny;
  logic [CW-1:0]         mag;
  logic [SHW-1:0]        lead, sh;
  logic                  in_zero;
  always_comb begin
    in_x = xr;
    in_y = yr;
    case (state)
      ATAN_A: begin in_x = c;       in_y = s; end
      ATAN_C: begin in_x = c + ONE; in_y = s; end
      default: ;
    endcase
    in_zero = (in_x == '0) && (in_y == '0);
    ex = CW'(in_x);
    ey = CW'(in_y);
    if (!in_x[W-1]) begin
      px = ex;  py = ey;  pz = '0;
    end else if (!in_y[W-1]) begin
      px = ey;  py = -ex; pz = PI_2;
    end else begin
      px = -ey; py = ex;  pz = -PI_2;
    end
    mag  = px | (py[CW-1] ? -py : py);
    lead = '0;
    for (int k = 0; k < CW; k++)
      if (mag[k]) lead = SHW'(k);
    sh = (lead < SHW'(W-2)) ? SHW'(W-2) - lead : '0;
    nx = px <<< sh;
    ny = py <<< sh;
  end

  // CORDIC vectoring micro-rotation
  logic [CNTW-1:0]       idx;
  logic signed [CW-1:0]  cx_nx, cy_nx;
  logic signed [W-1:0]   cz_nx, result;
  always_comb begin
    idx = cnt - CNTW'(1);
    if (!cy[CW-1]) begin
      cx_nx = cx + (cy >>> idx);
      cy_nx = cy - (cx >>> idx);
      cz_nx = cz + atan_tab(int'(idx));
    end else begin
      cx_nx = cx - (cy >>> idx);
      cy_nx = cy + (cx >>> idx);
      cz_nx = cz - atan_tab(int'(idx));
    end
    result = czero ? '0 : cz_nx;
  end

  // a - b wrapped into [-pi, pi]; theta2 clamped against CORDIC residue at the range ends
  logic signed [W-1:0] d1, t1_w, t2_c;
  always_comb begin
    d1 = ang_b - ang_c;
    if (d1 > PI)       t1_w = d1 - TWO_PI;
    else if (d1 < -PI) t1_w = d1 + TWO_PI;
    else               t1_w = d1;
    if (ang_a[W-1])    t2_c = '0;
    else if (ang_a > PI) t2_c = PI;
    else               t2_c = ang_a;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = SQUARE;
      SQUARE:  state_nx = SQRT;
      SQRT:    if (cnt == SQ_LAST) state_nx = ATAN_A;
      ATAN_A:  if (cnt == AT_LAST) state_nx = ATAN_B;
      ATAN_B:  if (cnt == AT_LAST) state_nx = ATAN_C;
      ATAN_C:  if (cnt == AT_LAST) state_nx = UPDATE;
      UPDATE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt <= '0;  xr <= '0;  yr <= '0;  c <= '0;  s <= '0;
      rad <= '0;  sq_r <= '0;  sq_q <= '0;
      cx <= '0;  cy <= '0;  cz <= '0;  czero <= 1'b0;
      ang_a <= '0;  ang_b <= '0;  ang_c <= '0;
      theta1 <= '0;  theta2 <= '0;
    end else begin
      cnt <= (state_nx != state) ? '0 : cnt + CNTW'(1);
      case (state)
        IDLE: begin
          xr <= x;
          yr <= y;
        end
        SQUARE: begin
          c    <= c_sq;
          rad  <= rad_sq;
          sq_r <= '0;
          sq_q <= '0;
        end
        SQRT: begin
          rad  <= rad << 2;
          sq_r <= r_nx;
          sq_q <= q_nx;
          if (cnt == SQ_LAST) s <= W'(q_nx);
        end
        ATAN_A, ATAN_B, ATAN_C: begin
          if (cnt == '0) begin
            cx    <= nx;
            cy    <= ny;
            cz    <= pz;
            czero <= in_zero;
          end else begin
            cx <= cx_nx;
            cy <= cy_nx;
            cz <= cz_nx;
            if (cnt == AT_LAST) begin
              if (state == ATAN_A)      ang_a <= result;
              else if (state == ATAN_B) ang_b <= result;
              else                      ang_c <= result;
            end
          end
        end
        UPDATE: begin
          theta1 <= t1_w;
          theta2 <= t2_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_kin.sv
// tb/tb_inv_kin.sv - self-checking bench for inv_kin against a real-arithmetic IK model
module tb_inv_kin;
  localparam int  PI_Q    = 102944;
  localparam int  TWO_PI  = 205888;
  localparam int  TOL     = 64;
  localparam int  SETTLE  = 240;
  localparam int  HOLD    = 10;
  localparam int  NRAND   = 120;
  localparam real PI_R    = 3.14159265358979323846;

  logic        clock = 1'b0;
  logic        rst;
  logic [31:0] x, y;
  logic [31:0] theta1, theta2;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_t1 = 0;
  int exp_t2 = 0;
  bit settled = 1'b0;

  inv_kin dut (
    .x(x), .y(y), .theta1(theta1), .theta2(theta2), .clock(clock), .rst(rst)
  );

  always #5 clock = ~clock;

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int circ(input int d);
    int r;
    r = d;
    while (r > PI_Q)  r = r - TWO_PI;
    while (r < -PI_Q) r = r + TWO_PI;
    return r;
  endfunction

  // Ideal IK for the clamped c: c from x^2+y^2 at Q.15, everything after in double precision
  task automatic model(input logic [31:0] xi, input logic [31:0] yi, output int t1, output int t2);
    longint xs, ys, c;
    longint unsigned sum, r2;
    real cr, sr, a, b, d;
    xs  = longint'(signed'(xi));
    ys  = longint'(signed'(yi));
    sum = longint'(xs * xs) + longint'(ys * ys);
    r2  = sum >> 15;
    c   = (r2 >= 64'd32768) ? 64'sd32768 : 2 * longint'(r2) - 64'sd32768;
    cr  = real'(c) / 32768.0;
    sr  = 1.0 - cr * cr;
    sr  = (sr > 0.0) ? $sqrt(sr) : 0.0;
    t2  = rnd($atan2(sr, cr) * 32768.0);
    a   = (xs == 0 && ys == 0) ? 0.0 : $atan2(real'(ys), real'(xs));
    b   = (sr == 0.0 && (1.0 + cr) == 0.0) ? 0.0 : $atan2(sr, 1.0 + cr);
    d   = a - b;
    if (d > PI_R)  d = d - 2.0 * PI_R;
    if (d < -PI_R) d = d + 2.0 * PI_R;
    t1  = rnd(d * 32768.0);
  endtask

  task automatic check_near(input string name, input int got, input int want, input bit wrap);
    int d;
    n_chk++;
    d = got - want;
    if (wrap) d = circ(d);
    if (d > TOL || d < -TOL) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d) at %0t", name, got, want, TOL, $time);
    end
  endtask

  task automatic check_eq(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Continuous compare against the model once the outputs are due to be settled
  always @(negedge clock) begin
    if (settled && !rst) begin
      check_near("theta1_vs_model", signed'(theta1), exp_t1, 1'b1);
      check_near("theta2_vs_model", signed'(theta2), exp_t2, 1'b0);
      n_chk++;
      if (signed'(theta2) < 0 || signed'(theta2) > PI_Q) begin
        n_fail++;
        $display("FAIL theta2_range: got %0d, expected within [0, %0d]", signed'(theta2), PI_Q);
      end
      n_chk++;
      if (signed'(theta1) < -PI_Q || signed'(theta1) > PI_Q) begin
        n_fail++;
        $display("FAIL theta1_range: got %0d, expected within [-%0d, %0d]", signed'(theta1), PI_Q, PI_Q);
      end
    end
  end

  task automatic hold_and_check();
    repeat (SETTLE) @(posedge clock);
    #1 settled = 1'b1;
    repeat (HOLD) @(posedge clock);
    #1 settled = 1'b0;
  endtask

  task automatic apply(input logic [31:0] xi, input logic [31:0] yi);
    int t1, t2;
    settled = 1'b0;
    model(xi, yi, t1, t2);
    exp_t1 = t1;
    exp_t2 = t2;
    @(posedge clock);
    #1 x = xi;
    y = yi;
    hold_and_check();
  endtask

  typedef struct {
    logic [31:0] vx;
    logic [31:0] vy;
    int          t1;
    int          t2;
  } vec_t;

  vec_t dir [7];

  initial begin
    int mt1, mt2, sel;
    logic [31:0] rx, ry;

    dir[0] = '{32'h0000_8000, 32'h0000_0000, 0,      0};
    dir[1] = '{32'h0000_0000, 32'h0000_8000, 51472,  0};
    dir[2] = '{32'h0000_4000, 32'h0000_4000, 0,      51472};
    dir[3] = '{32'h0000_0000, 32'h0000_4000, 17157,  68629};
    dir[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 25736,  0};
    dir[5] = '{32'h0000_0000, 32'h0000_0000, 0,      102944};
    dir[6] = '{32'hFFFF_8000, 32'h0000_0000, 102944, 0};

    rst = 1'b1;
    x   = 32'h0;
    y   = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset_theta1", signed'(theta1), 0);
    check_eq("reset_theta2", signed'(theta2), 0);
    rst = 1'b0;

    apply(32'h0000_4000, 32'h0000_4000);
    repeat (37) @(posedge clock);
    #3 rst = 1'b1;
    #1;
    check_eq("async_reset_theta1", signed'(theta1), 0);
    check_eq("async_reset_theta2", signed'(theta2), 0);
    @(posedge clock);
    #1 rst = 1'b0;
    hold_and_check();
    check_near("post_reset_theta1", signed'(theta1), 0, 1'b1);
    check_near("post_reset_theta2", signed'(theta2), 51472, 1'b0);

    for (int i = 0; i < 7; i++) begin
      model(dir[i].vx, dir[i].vy, mt1, mt2);
      check_near($sformatf("model_t1_case%0d", i), mt1, dir[i].t1, 1'b1);
      check_near($sformatf("model_t2_case%0d", i), mt2, dir[i].t2, 1'b0);
      apply(dir[i].vx, dir[i].vy);
      check_near($sformatf("dut_t1_case%0d", i), signed'(theta1), dir[i].t1, 1'b1);
      check_near($sformatf("dut_t2_case%0d", i), signed'(theta2), dir[i].t2, 1'b0);
    end

    for (int i = 0; i < NRAND; i++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        rx = $urandom;
        ry = $urandom;
      end else if (sel == 1) begin
        rx = 32'($urandom_range(0, 32'hC000)) - 32'h6000;
        ry = 32'($urandom_range(0, 32'hC000)) - 32'h6000;
      end else begin
        rx = 32'($urandom_range(0, 32'h400)) - 32'h200;
        ry = 32'($urandom_range(0, 32'h400)) - 32'h200;
      end
      apply(rx, ry);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
